// File: rtl/llc_wb_addr_gen.sv
// LLC writeback address generator: queues dirty (M) victims as line addresses for the bus.
// Define LLC_WB_STATS_EN to enable the saturating wb_count / clean_count statistics.
module llc_wb_addr_gen #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 14,
    parameter int DEPTH    = 4,
    localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               evict_valid,
    output logic               evict_ready,
    input  logic [TAG_W-1:0]   evict_tag,
    input  logic [INDEX_W-1:0] evict_index,
    input  logic [1:0]         evict_mesi,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [ADDR_W-1:0]  wb_addr,
    output logic [15:0]        wb_count,
    output logic [15:0]        clean_count
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never depends on ready, and ready never depends on valid.

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int LINE_W = TAG_W + INDEX_W;
    localparam logic [1:0] MESI_M = 2'd3;

    logic [LINE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    logic full;
    logic empty;
    logic accept;
    logic push;
    logic drop;
    logic pop;

    assign full   = (occ == OCC_W'(DEPTH));
    assign empty  = (occ == '0);
    assign accept = evict_valid && evict_ready;
    assign push   = accept && (evict_mesi == MESI_M);
    assign drop   = accept && (evict_mesi != MESI_M);
    assign pop    = wb_valid && wb_ready && !rst;

    assign evict_ready = !rst && !full;
    assign wb_valid    = !empty;
    // Gating on empty keeps the address at 0 after reset and hides stale slots.
    assign wb_addr     = empty ? '0 : {mem[rd_ptr], {OFFSET_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {evict_tag, evict_index};
        end
    end

    // DEPTH is a power of two, so pointer increments wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef LLC_WB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_count    <= '0;
            clean_count <= '0;
        end else begin
            if (pop && (wb_count != 16'hFFFF)) begin
                wb_count <= wb_count + 16'd1;
            end
            if (drop && (clean_count != 16'hFFFF)) begin
                clean_count <= clean_count + 16'd1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign wb_count    = '0;
    assign clean_count = '0;
`endif

endmodule

// File: tb/tb_llc_wb_addr_gen.sv
// Self-checking bench for llc_wb_addr_gen: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_llc_wb_addr_gen;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 14;
    localparam int DEPTH    = 4;
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;

    logic               clk;
    logic               rst;
    logic               evict_valid;
    logic               evict_ready;
    logic [TAG_W-1:0]   evict_tag;
    logic [INDEX_W-1:0] evict_index;
    logic [1:0]         evict_mesi;
    logic               wb_valid;
    logic               wb_ready;
    logic [ADDR_W-1:0]  wb_addr;
    logic [15:0]        wb_count;
    logic [15:0]        clean_count;

    llc_wb_addr_gen #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .evict_valid(evict_valid), .evict_ready(evict_ready),
        .evict_tag(evict_tag), .evict_index(evict_index), .evict_mesi(evict_mesi),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_count(wb_count), .clean_count(clean_count)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard: expected writeback addresses in order, plus event counts
    logic [ADDR_W-1:0] exp_q[$];
    int unsigned       m_pops;
    int unsigned       m_drops;
    int                n_tests;
    int                n_fail;

    function automatic logic [ADDR_W-1:0] line_addr(input int unsigned tag, input int unsigned idx);
        return ADDR_W'(tag * (1 << (INDEX_W + OFFSET_W)) + idx * (1 << OFFSET_W));
    endfunction

    function automatic logic [15:0] sat16(input int unsigned v);
`ifdef LLC_WB_STATS_EN
        return (v > 65535) ? 16'hFFFF : 16'(v);
`else
        return (v == 32'hFFFF_FFFF) ? 16'd1 : 16'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic v, input int unsigned tag, input int unsigned idx,
                         input logic [1:0] mesi, input logic rdy);
        evict_valid = v;
        evict_tag   = TAG_W'(tag);
        evict_index = INDEX_W'(idx);
        evict_mesi  = mesi;
        wb_ready    = rdy;
    endtask

    // One cycle: check all outputs against the model, take the edge, update the model.
    task automatic step();
        logic acc;
        logic pp;
        #1;
        check("evict_ready", 32'(evict_ready), 32'(!rst && (exp_q.size() < DEPTH)));
        check("wb_valid", 32'(wb_valid), 32'(exp_q.size() != 0));
        check("wb_addr", wb_addr, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        check("wb_count", 32'(wb_count), 32'(sat16(m_pops)));
        check("clean_count", 32'(clean_count), 32'(sat16(m_drops)));
        acc = evict_valid && !rst && (exp_q.size() < DEPTH);
        pp  = wb_ready && !rst && (exp_q.size() != 0);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_pops  = 0;
            m_drops = 0;
        end else begin
            if (pp) begin
                void'(exp_q.pop_front());
                m_pops++;
            end
            if (acc) begin
                if (evict_mesi == 2'd3) exp_q.push_back(line_addr(evict_tag, evict_index));
                else m_drops++;
            end
        end
        #1;
    endtask

    logic [ADDR_W-1:0] first_addr;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_pops  = 0;
        m_drops = 0;
        rst = 1'b1;
        drive(1'b0, 0, 0, 2'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_wb_addr", wb_addr, 32'h0);

        // single M eviction with a known address
        drive(1'b1, 'hABC, 'h0123, 2'd3, 1'b1);
        step();
        drive(1'b0, 0, 0, 2'd0, 1'b1);
        #1;
        check("req037_valid", 32'(wb_valid), 32'd1);
        check("req037_addr", wb_addr, 32'hABC048C0);
        step();
        step();

        // clean evictions are dropped silently
        for (int m = 0; m < 3; m++) begin
            drive(1'b1, 100 + m, 200 + m, 2'(m), 1'b0);
            step();
        end
        drive(1'b0, 0, 0, 2'd0, 1'b0);
        step();
`ifdef LLC_WB_STATS_EN
        check("clean_three", 32'(clean_count), 32'd3);
`endif

        // fill the queue with ready low; 5th eviction must stall
        first_addr = line_addr(11, 21);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 11 + k, 21 + k, 2'd3, 1'b0);
            if (k == 4) begin
                #1;
                check("full_not_ready", 32'(evict_ready), 32'd0);
                check("full_head_held", wb_addr, first_addr);
            end
            step();
        end
        // drain while the 5th eviction keeps waiting
        wb_ready = 1'b1;
        step();
        #1;
        check("ready_after_pop", 32'(evict_ready), 32'd1);
        step();
        evict_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // reset with three entries queued
        wb_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 300 + k, 400 + k, 2'd3, 1'b0);
            step();
        end
        drive(1'b0, 0, 0, 2'd0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_count", 32'(wb_count), 32'd0);
        for (int k = 0; k < 3; k++) step();

        // random traffic, with an occasional reset
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 4095), $urandom_range(0, 16383),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
            rst = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0;

`ifdef LLC_WB_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 70002; k++) begin
            drive(1'b1, k % 4096, k % 16384, 2'd3, 1'b1);
            step();
        end
        check("wb_count_sat", 32'(wb_count), 32'h0000FFFF);
`else
        for (int k = 0; k < 200; k++) begin
            drive(1'b1, k, 3 * k, 2'd3, 1'b1);
            step();
        end
`endif
        drive(1'b0, 0, 0, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
